// File: rtl/tia_object_position_counter.sv
// One TIA movable-object position counter: a 2-bit phase divider feeding a
// 6-bit XNOR polynomial counter, advanced by motck and HMOVE extra clocks.
module tia_object_position_counter #(
  parameter logic [5:0] END_CODE   = 6'b101101,
  parameter logic [5:0] RESET_CODE = 6'b000000
) (
  input  logic       clk,
  input  logic       r,
  input  logic       motck,
  input  logic       hmove_go,
  input  logic       hmove_tick,
  input  logic [3:0] motion,
  input  logic       resp,
  output logic [5:0] lfsr,
  output logic [1:0] phase,
  output logic       start,
  output logic       hm_busy
);

  logic [3:0] hmc_r;
  logic       xen_r;
  logic [3:0] target_s;
  logic       tick_s;
  logic       hit_s;
  logic       xclk_s;
  logic       adv_s;

  function automatic logic [5:0] lfsr_step(input logic [5:0] v);
    return {v[4:0], ~(v[5] ^ v[4])};
  endfunction

  // Extra-clock qualification; hmove_go discards a coincident tick.
  always_comb begin
    target_s = motion ^ 4'b1000;
    tick_s   = 1'b0;
    hit_s    = 1'b0;
    xclk_s   = 1'b0;
    if (hmove_tick && hm_busy && !hmove_go) begin
      tick_s = 1'b1;
      hit_s  = (hmc_r == target_s);
      xclk_s = xen_r && !hit_s;
    end else begin
      tick_s = 1'b0;
    end
    adv_s = motck | xclk_s;
  end

  // Position divider, polynomial counter, wrap pulse and HMOVE window state.
  always_ff @(posedge clk) begin
    if (r) begin
      lfsr    <= RESET_CODE;
      phase   <= 2'd0;
      start   <= 1'b0;
      hm_busy <= 1'b0;
      hmc_r   <= 4'd0;
      xen_r   <= 1'b0;
    end else begin
      start <= 1'b0;
      // resp only moves the position; the HMOVE window keeps running.
      if (resp) begin
        lfsr  <= RESET_CODE;
        phase <= 2'd0;
      end else if (adv_s) begin
        phase <= phase + 2'd1;
        if (phase == 2'd3) begin
          if (lfsr == END_CODE) begin
            lfsr  <= 6'b000000;
            start <= 1'b1;
          end else begin
            lfsr <= lfsr_step(lfsr);
          end
        end
      end

      if (hmove_go) begin
        hmc_r   <= 4'd0;
        xen_r   <= 1'b1;
        hm_busy <= 1'b1;
      end else if (tick_s) begin
        if (hit_s) begin
          xen_r <= 1'b0;
        end
        hmc_r <= hmc_r + 4'd1;
        if (hmc_r == 4'd15) begin
          hm_busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tia_object_position_counter.sv
// Scoreboarded bench: two counters (default wrap and a short 000111 wrap)
// share stimulus and are checked against an index-into-sequence model.
module tb_tia_object_position_counter;

  localparam logic [5:0] END0 = 6'b101101;
  localparam logic [5:0] END1 = 6'b000111;
  localparam logic [5:0] RST  = 6'b000000;

  logic       clk = 1'b0;
  logic       r = 1'b1, motck = 1'b0, hmove_go = 1'b0, hmove_tick = 1'b0, resp = 1'b0;
  logic [3:0] motion = 4'd0;
  logic [5:0] lfsr0, lfsr1;
  logic [1:0] phase0, phase1;
  logic       start0, start1, busy0, busy1;

  typedef struct packed {
    logic [5:0] l0;
    logic [5:0] l1;
    logic [1:0] ph;
    logic       s0;
    logic       s1;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [5:0] seq0[64];
  logic [5:0] seq1[64];
  int len0 = 0, len1 = 0;
  int m_pos0 = 0, m_pos1 = 0, m_phase = 0, m_ticks = 0;
  bit m_busy = 1'b0;

  tia_object_position_counter #(.END_CODE(END0), .RESET_CODE(RST)) u_dut (
    .clk(clk), .r(r), .motck(motck), .hmove_go(hmove_go), .hmove_tick(hmove_tick),
    .motion(motion), .resp(resp), .lfsr(lfsr0), .phase(phase0), .start(start0),
    .hm_busy(busy0));

  tia_object_position_counter #(.END_CODE(END1), .RESET_CODE(RST)) u_wrap (
    .clk(clk), .r(r), .motck(motck), .hmove_go(hmove_go), .hmove_tick(hmove_tick),
    .motion(motion), .resp(resp), .lfsr(lfsr1), .phase(phase1), .start(start1),
    .hm_busy(busy1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs and push the state expected after the next edge.
  task automatic drive(input bit r_i, input bit m_i, input bit g_i, input bit t_i,
                       input bit p_i, input logic [3:0] mot_i);
    bit   tick_eff, xclk, adv, s0, s1;
    int   extras;
    exp_t e;
    @(negedge clk);
    r = r_i; motck = m_i; hmove_go = g_i; hmove_tick = t_i; resp = p_i; motion = mot_i;
    s0 = 1'b0; s1 = 1'b0;
    if (r_i) begin
      m_pos0 = 0; m_pos1 = 0; m_phase = 0; m_busy = 1'b0; m_ticks = 0;
    end else begin
      extras   = int'(mot_i ^ 4'b1000);
      tick_eff = t_i && m_busy && !g_i;
      xclk     = tick_eff && (m_ticks < extras);
      adv      = m_i || xclk;
      if (p_i) begin
        m_pos0 = 0; m_pos1 = 0; m_phase = 0;
      end else if (adv) begin
        if (m_phase == 3) begin
          m_pos0++;
          if (m_pos0 == len0) begin m_pos0 = 0; s0 = 1'b1; end
          m_pos1++;
          if (m_pos1 == len1) begin m_pos1 = 0; s1 = 1'b1; end
        end
        m_phase = (m_phase + 1) % 4;
      end
      if (g_i) begin
        m_busy = 1'b1; m_ticks = 0;
      end else if (tick_eff) begin
        m_ticks++;
        if (m_ticks == 16) m_busy = 1'b0;
      end
    end
    e.l0 = seq0[m_pos0]; e.l1 = seq1[m_pos1]; e.ph = m_phase[1:0];
    e.s0 = s0; e.s1 = s1; e.busy = m_busy;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit m_i, input logic [3:0] mot_i);
    for (int i = 0; i < n; i++) drive(1'b0, m_i, 1'b0, 1'b0, 1'b0, mot_i);
  endtask

  task automatic ticks(input int n, input bit m_i, input logic [3:0] mot_i);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, m_i, 1'b0, 1'b1, 1'b0, mot_i);
      idle(3, 1'b0, mot_i);
    end
  endtask

  // Monitor: compare every presented output set against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("lfsr_default", int'(lfsr0), int'(e.l0));
        chk("lfsr_short", int'(lfsr1), int'(e.l1));
        chk("phase", int'(phase0), int'(e.ph));
        chk("phase_short", int'(phase1), int'(e.ph));
        chk("start_default", int'(start0), int'(e.s0));
        chk("start_short", int'(start1), int'(e.s1));
        chk("hm_busy", int'(busy0), int'(e.busy));
        chk("hm_busy_short", int'(busy1), int'(e.busy));
      end
    end
  end

  initial begin
    logic [5:0] v;
    logic [3:0] mot;
    v = RST;
    for (int k = 0; k < 64; k++) begin
      seq0[k] = v;
      if (v == END0) begin len0 = k + 1; break; end
      v = {v[4:0], ~(v[5] ^ v[4])};
    end
    v = RST;
    for (int k = 0; k < 64; k++) begin
      seq1[k] = v;
      if (v == END1) begin len1 = k + 1; break; end
      v = {v[4:0], ~(v[5] ^ v[4])};
    end
    if (len0 == 0 || len1 == 0) begin
      $display("FAIL model_sequence: len0 %0d len1 %0d expected nonzero", len0, len1);
      $fatal(1);
    end

    // Reset, then continuous motck through several wraps of both counters.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    idle(24 + 4 * len0 + 8, 1'b1, 4'd0);

    // HMOVE extra-clock counts for several motion values with motck idle.
    for (int i = 0; i < 4; i++) begin
      mot = (i == 0) ? 4'd0 : (i == 1) ? 4'd7 : (i == 2) ? 4'd8 : 4'd9;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mot);
      ticks(16, 1'b0, mot);
      idle(3, 1'b0, mot);
    end

    // motck coincident with extra clocks; go coincident with tick.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    ticks(3, 1'b1, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    ticks(16, 1'b1, 4'd0);

    // resp at phase 3 on the short counter's end code, then during HMOVE.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    idle(15, 1'b1, 4'd3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    ticks(4, 1'b0, 4'd3);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
    ticks(12, 1'b0, 4'd3);

    // Reset mid-window: later ticks must not advance anything.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
    ticks(5, 1'b0, 4'd7);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7);
    ticks(6, 1'b0, 4'd7);

    // Randomized traffic; motion only changes outside a window.
    mot = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      if (!m_busy && $urandom_range(0, 7) == 0) mot = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 59) == 0, mot);
    end

    idle(1, 1'b0, mot);
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tia_object_position_counter.md
Name: tia_object_position_counter

Overview:
- Downstream consumer of the horizontal timing stage.
- Models one TIA movable-object position counter (player/missile/ball): a 2-bit phase divider feeding a 6-bit polynomial counter.
- Advanced by the motion clock enable `motck` plus HMOVE extra clocks.
- Emits a one-cycle `start` pulse each time the object's horizontal position wraps; the graphics serialiser consumes it.

Parameters:
- END_CODE, 6'b101101, LFSR value at which the next step reloads 6'b000000 instead of shifting.
- RESET_CODE, 6'b000000, LFSR value loaded by `r` and `resp`.

Ports:
- clk  in  1  master colour clock
- r  in  1  reset; synchronous, active-high
- motck  in  1  motion clock enable, one cycle per unblanked colour clock (from horizontal timing)
- hmove_go  in  1  single-cycle pulse; starts an HMOVE extra-clock window
- hmove_tick  in  1  single-cycle strobe, one per 4 colour clocks during HMOVE (from horizontal timing)
- motion  in  4  HMxx[7:4], two's complement, latched externally
- resp  in  1  single-cycle position reset strobe (RESPx write)
- lfsr  out  6  current polynomial counter value
- phase  out  2  divider phase
- start  out  1  one-cycle wrap pulse
- hm_busy  out  1  HMOVE window active

Behaviour:
- All state updates on posedge `clk`.
- `r` has top priority. Reset values: `lfsr`=RESET_CODE, `phase`=0, `start`=0, `hm_busy`=0, `hmc`=0, `xen`=0.
- Advance: `adv` = `motck` | `xclk`. When both are high in the same cycle, this is a single advance, never two.
- Divider: each `adv` increments `phase` mod 4. On an `adv` with `phase`==3, the LFSR steps.
- LFSR step:
  - if `lfsr`==END_CODE: next = 6'b000000 and `start`=1 the following cycle;
  - else: next = {lfsr[4:0], lfsr[5] XNOR lfsr[4]}.
- `start` is registered, high for exactly one cycle per wrap, and otherwise 0.
- `resp` (when `r` is low): loads `lfsr`=RESET_CODE and `phase`=0. It overrides a coincident `adv`, generates no `start`, and leaves the HMOVE state untouched.
- HMOVE state: 4-bit counter `hmc`, extra-enable flag `xen`, `hm_busy`.
- `hmove_go`: `hmc`=0, `xen`=1, `hm_busy`=1. Valid whether or not a window is active: a retrigger mid-window restarts cleanly.
- `hmove_tick` with `hm_busy`=1:
  - if `xen` and `hmc` != (`motion` ^ 4'b1000): `xclk`=1 for that cycle (combinational from the tick).
  - if `hmc` == (`motion` ^ 4'b1000): `xen`=0 and no `xclk`.
  - then `hmc` increments. On the tick processed with `hmc`==15, `hm_busy` clears next cycle (16 ticks per window).
- Extra clocks per window = `motion` ^ 8:
  - `motion`=0 gives 8;
  - `motion`=7 gives 15;
  - `motion`=8 (−8) gives 0.
- `hmove_tick` with `hm_busy`=0 is ignored.
- `hmove_go` and `hmove_tick` in the same cycle: `go` wins and the tick is discarded.
- `motion` is sampled live on every tick. A change mid-window changes the compare target immediately.

Test Plan:
- Reset/step: assert `r` 2 cycles, then `motck` held 1 → `lfsr` reads 000001 after 4 advances, 000011 after 8, 011111 after 20, 111110 after 24; `phase` cycles 0,1,2,3.
- Wrap (END_CODE=6'b000111 override): continuous `motck` → `lfsr` sequence 0,1,3,7,0. First `start` occurs 1 cycle after the 16th advance, then every 16 advances, each pulse exactly 1 cycle wide.
- HMOVE counts: `motck`=0, `hmove_go`, then 16 spaced `hmove_tick`s → total `phase` advances are 8 for `motion`=0, 15 for 7, 0 for 8, 1 for 9. `hm_busy` falls after the 16th tick.
- Collision: `motck` and an extra clock in the same cycle → `phase` advances by 1. `hmove_go` coincident with `hmove_tick` → no `xclk` that cycle, `hmc`=0.
- RESP priority: `resp` with `motck`, at `phase`=3, `lfsr`=END_CODE → `lfsr`=0, `phase`=0, no `start`. During an active HMOVE, the remaining extra clocks continue.
- Reset mid-window: `r` asserted after 5 ticks → `hm_busy`=0, `lfsr`=0. Later ticks produce no advances until the next `hmove_go`.
